ct_f_spsram_ctrl: RTL
=====================

Name: ct_f_spsram_ctrl

Overview:
- Request-side controller that sits directly upstream of the single-port FPGA SRAM macro (ct_f_spsram_256x144 and family).
- Converts a valid/ready read/write request stream into the macro's active-low CEN/GWEN/WEN strobes.
- Captures the macro's Q one cycle after each read into a 2-entry response FIFO with valid/ready backpressure.
- Optionally zero-fills the whole array after reset.

Parameters:
ADDR_WIDTH, 8, SRAM address width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 144, SRAM word width.

Ports:
CLK  in  1  clock, shared with the SRAM macro
RST  in  1  synchronous reset, active-high
req_vld  in  1  request valid
req_rdy  out  1  request ready; handshake completes when req_vld && req_rdy
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  DATA_WIDTH  per-bit write enable, active-high
rsp_vld  out  1  read data valid
rsp_rdy  in  1  read data accepted
rsp_rdata  out  DATA_WIDTH  read data
init_done  out  1  array ready for requests
A  out  ADDR_WIDTH  to SRAM A
CEN  out  1  to SRAM CEN, active-low
D  out  DATA_WIDTH  to SRAM D
GWEN  out  1  to SRAM GWEN, active-low
WEN  out  DATA_WIDTH  to SRAM WEN, active-low per bit
Q  in  DATA_WIDTH  from SRAM Q

Behaviour:
- Single clock CLK. RST is synchronous and active-high.
- Reset values: rsp_vld=0, rsp_rdata=0, FIFO empty, inflight=0, CEN=1, GWEN=1, WEN=all-ones.
- SRAM strobes are combinational from the accepted request, so the access occurs in the handshake cycle.
- Write accept: CEN=0, GWEN=0, WEN=~req_wmask, A=req_addr, D=req_wdata. Produces no response.
- Read accept: CEN=0, GWEN=1, WEN=all-ones, A=req_addr.
- No accept (run state): CEN=1, GWEN=1, WEN=all-ones. A=req_addr and D=req_wdata pass through but are don't-care.
- Read latency: inflight register is set on the read-accept cycle. On the next cycle Q is pushed into the FIFO. rsp_vld rises that same cycle (1-cycle SRAM plus comb-out of the FIFO head).
- Total request-to-rsp_vld latency is 1 cycle when the FIFO is empty.
- Credit rule: occupancy = fifo_count + inflight. req_rdy = init_done && occupancy < 2, or occupancy==2 with a FIFO pop this cycle (rsp_vld && rsp_rdy).
- req_rdy never depends on req_vld or req_wr.
- Throughput: one read per cycle sustained while rsp_rdy=1.
- FIFO: 2 entries, in-order. Simultaneous push and pop keeps the count unchanged. Pop on empty and push on full cannot occur by construction; the checker must flag either.
- rsp_rdata holds stable while rsp_vld && !rsp_rdy.
- Read-after-write to the same address in consecutive cycles returns the new data. Only bits set in req_wmask change.
- Writes and reads are accepted under the same credit rule; writes never enter the FIFO.
- FSM states (feature enabled): INIT, RUN. Without the feature: RUN only.
- RST asserted at any time returns the FSM to INIT (or RUN without the feature), empties the FIFO, and clears inflight. A read in flight at reset is discarded.

Optional Feature:
Macro CT_SPSRAM_CTRL_INIT_EN.
- Defined:
  - After RST deasserts, the FSM is in INIT with a counter at 0.
  - Each cycle it drives CEN=0, GWEN=0, WEN=all-zeros, D=0, A=counter, then increments.
  - After address 2**ADDR_WIDTH-1 is written, the FSM moves to RUN: 256 cycles at default.
  - During INIT: init_done=0, req_rdy=0.
  - In RUN: init_done=1.
  - RST mid-INIT restarts the sweep from address 0.
- Undefined: no counter. init_done=1 constantly, and req_rdy may assert in the first cycle after reset. Array contents are unknown until written.

Test Plan:
- Init sweep (macro on): release RST → exactly 256 cycles of CEN=0/GWEN=0/WEN=0 with A=0..255. Then init_done=1. Read addr 0x7F → rsp_rdata=0.
- Masked write: write addr 0x10, data all-ones, mask 0x…00FF. Next cycle read 0x10 → rsp_rdata=0x…00FF (after init) 1 cycle after the read accept.
- Back-to-back reads 0x01..0x08 with rsp_rdy=1 → 8 responses on consecutive cycles, in order, data matching prior writes.
- Backpressure: rsp_rdy=0, issue reads → exactly 2 accepted, then req_rdy=0 and rsp_rdata stable. Raise rsp_rdy → req_rdy=1 in the same cycle, remaining reads complete in order.
- Simultaneous push/pop with the FIFO holding 1 entry and a read in flight → count stays 1, no data loss or duplication.
- Reset mid-operation: assert RST with 2 responses queued and 1 in flight → next cycle rsp_vld=0, CEN=1. With the macro on, the sweep restarts at A=0.

Source files
------------

// File: rtl/ct_f_spsram_ctrl.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_ctrl
//
// Request-side controller for the single-port SRAM macro
// (ct_f_spsram_256x144 family). Converts a valid/ready request stream into
// the macro's active-low CEN/GWEN/WEN strobes. It captures read data one
// cycle after each read into a 2-entry in-order response FIFO with
// valid/ready backpressure.
//
// Optional feature (macro CT_SPSRAM_CTRL_INIT_EN): after reset, zero-fill the
// whole array (one word per cycle) before any request is accepted.
// Without the macro the controller starts directly in RUN.
//
// Ports:
//   CLK        clock, shared with the SRAM macro
//   RST        synchronous reset, active-high
//   req_vld    request valid
//   req_rdy    request ready (credit based, independent of req_vld/req_wr)
//   req_wr     1 = write, 0 = read
//   req_addr   request address
//   req_wdata  write data
//   req_wmask  per-bit write enable, active-high
//   rsp_vld    read data valid
//   rsp_rdy    read data accepted
//   rsp_rdata  read data (0 when rsp_vld is low)
//   init_done  array ready for requests
//   A, CEN, D, GWEN, WEN   to SRAM macro (strobes active-low)
//   Q          from SRAM macro
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_INIT | zero-fill sweep in progress, requests blocked
//   ST_RUN  | normal operation, requests accepted under the credit rule
// ----------------------------------------------------------------------------
module ct_f_spsram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 144
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic [DATA_WIDTH-1:0] D,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] Q
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Read in flight: a read was issued to the macro last cycle, so Q now
    // holds its data.
    logic inflight;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;

    logic [1:0] occupancy;
    logic       accept;
    logic       rd_accept;
    logic       pop;
    logic       bypass;
    logic       fifo_push;
    logic       fifo_pop;

`ifdef CT_SPSRAM_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt;
`endif

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
            state <= ST_INIT;
`else
            state <= ST_RUN;
`endif
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
                // Leave once the last address has been written this cycle.
                if (init_cnt == '1) state_nxt = ST_RUN;
`else
                state_nxt = ST_RUN;
`endif
            end
            ST_RUN:  state_nxt = ST_RUN;
        endcase
    end

`ifdef CT_SPSRAM_CTRL_INIT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Credit / handshake
    // ------------------------------------------------------------------------
    // Outputs are gated by RST so the strobes show their idle values for the
    // whole time reset is held, not only after the first reset edge.
    assign init_done = !RST && (state == ST_RUN);

    assign occupancy = fifo_cnt + {1'b0, inflight};
    assign pop       = rsp_vld && rsp_rdy;

    // A pop frees a slot in the same cycle, so a full controller can still
    // accept while the consumer drains.
    assign req_rdy   = init_done && ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
    assign accept    = req_vld && req_rdy;
    assign rd_accept = accept && !req_wr;

    // ------------------------------------------------------------------------
    // SRAM strobes (combinational: the access happens in the handshake cycle)
    // ------------------------------------------------------------------------
    always_comb begin
        A    = req_addr;
        D    = req_wdata;
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        if (!RST) begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
            if (state == ST_INIT) begin
                A    = init_cnt;
                D    = '0;
                CEN  = 1'b0;
                GWEN = 1'b0;
                WEN  = '0;
            end else
`endif
            if (accept) begin
                CEN = 1'b0;
                if (req_wr) begin
                    GWEN = 1'b0;
                    WEN  = ~req_wmask;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------------
    // When the FIFO is empty the in-flight Q is presented directly, giving a
    // one-cycle request-to-response latency. If that word is taken the same
    // cycle it never enters the FIFO; otherwise it is pushed at the edge, so
    // rsp_rdata stays stable under backpressure (Q does not change while no
    // new access is issued... and the FIFO copy takes over afterwards).
    assign rsp_vld   = (fifo_cnt != 2'd0) || inflight;
    assign rsp_rdata = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] :
                       (inflight ? Q : '0);

    assign bypass    = inflight && (fifo_cnt == 2'd0) && pop;
    assign fifo_push = inflight && !bypass;
    assign fifo_pop  = pop && (fifo_cnt != 2'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight <= 1'b0;
            fifo_cnt <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            inflight <= rd_accept;
            if (fifo_push) wr_ptr <= ~wr_ptr;
            if (fifo_pop)  rd_ptr <= ~rd_ptr;
            if (fifo_push && !fifo_pop) begin
                fifo_cnt <= fifo_cnt + 2'd1;
            end else if (!fifo_push && fifo_pop) begin
                fifo_cnt <= fifo_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fifo_push) fifo_mem[wr_ptr] <= Q;
    end

`ifndef SYNTHESIS
    // FIFO over/underflow is excluded by the credit rule; flag it if it ever
    // happens.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(fifo_pop && (fifo_cnt == 2'd0)));
            assert (!(fifo_push && !fifo_pop && (fifo_cnt == 2'd2)));
            assert (occupancy <= 2'd2);
        end
    end
`endif

endmodule
